dart_scorer: RTL

Game-level scorekeeper placed directly downstream of the per-throw dart scoring logic. Each accepted throw delivers a 2-bit point value (0–3); the block accumulates it into the active player's total. It rotates turns between two players and declares a winner or a draw. All state is registered on a single clock, and the block exposes totals and game status to the display/LED stage.

---
 rtl/dart_scorer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dart_scorer.sv
// Two-player dart game scorekeeper: accumulates 0-3 point throws, rotates turns, declares winner/draw.
// One-cycle latency from throw_valid to updated registered outputs; accepts one throw per cycle, never stalls.
module dart_scorer #(
  parameter int TARGET          = 15,
  parameter int THROWS_PER_TURN = 3,
  parameter int MAX_ROUNDS      = 8,
  parameter int SCORE_W         = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               throw_valid,
  input  logic [1:0]         points,
  output logic [SCORE_W-1:0] score_p0,
  output logic [SCORE_W-1:0] score_p1,
  output logic               active_player,
  output logic [1:0]         throw_idx,
  output logic [3:0]         round,
  output logic               throw_ack,
  output logic               game_over,
  output logic               winner,
  output logic               draw
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int           SW1      = SCORE_W + 1;
  localparam logic [1:0]   LAST_IDX = 2'(THROWS_PER_TURN - 1);
  localparam logic [3:0]   MAX_R    = 4'(MAX_ROUNDS);
  localparam logic [31:0]  TGT      = 32'(TARGET);
  localparam logic [SCORE_W-1:0] SAT = {SCORE_W{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] score0_q, score0_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic               active_q, active_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         round_q, round_d;
  logic               ack_q, ack_d;
  logic               winner_q, winner_d;
  logic               draw_q, draw_d;

  logic [SCORE_W-1:0] cur_score;
  logic [SW1-1:0]     sum;
  logic [SCORE_W-1:0] new_tot;
  logic [SCORE_W-1:0] new0, new1;

  // Saturating add of the throw onto the active player's total.
  assign cur_score = active_q ? score1_q : score0_q;
  assign sum       = {1'b0, cur_score} + SW1'(points);
  assign new_tot   = sum[SCORE_W] ? SAT : sum[SCORE_W-1:0];
  assign new0      = active_q ? score0_q : new_tot;
  assign new1      = active_q ? new_tot  : score1_q;

  always_comb begin
    state_d  = state_q;
    score0_d = score0_q;
    score1_d = score1_q;
    active_d = active_q;
    idx_d    = idx_q;
    round_d  = round_q;
    ack_d    = 1'b0;
    winner_d = winner_q;
    draw_d   = draw_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start has priority; any concurrent throw is dropped
        if (start) begin
          state_d  = ST_PLAY;
          score0_d = '0;
          score1_d = '0;
          active_d = 1'b0;
          idx_d    = '0;
          round_d  = '0;
          winner_d = 1'b0;
          draw_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        if (throw_valid) begin
          ack_d    = 1'b1;
          score0_d = new0;
          score1_d = new1;
          if (32'(new_tot) >= TGT) begin
            state_d  = ST_DONE;
            winner_d = active_q;
            draw_d   = 1'b0;
          end else if (idx_q < LAST_IDX) begin
            idx_d = idx_q + 2'd1;
          end else begin
            idx_d    = '0;
            active_d = ~active_q;
            if (active_q) begin
              round_d = round_q + 4'd1;
              if (round_q + 4'd1 == MAX_R) begin
                state_d  = ST_DONE;
                draw_d   = (new0 == new1);
                winner_d = (new1 > new0);
              end
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      score0_q <= '0;
      score1_q <= '0;
      active_q <= 1'b0;
      idx_q    <= '0;
      round_q  <= '0;
      ack_q    <= 1'b0;
      winner_q <= 1'b0;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      score0_q <= score0_d;
      score1_q <= score1_d;
      active_q <= active_d;
      idx_q    <= idx_d;
      round_q  <= round_d;
      ack_q    <= ack_d;
      winner_q <= winner_d;
      draw_q   <= draw_d;
    end
  end

  assign score_p0      = score0_q;
  assign score_p1      = score1_q;
  assign active_player = active_q;
  assign throw_idx     = idx_q;
  assign round         = round_q;
  assign throw_ack     = ack_q;
  assign game_over     = (state_q == ST_DONE);
  assign winner        = winner_q;
  assign draw          = draw_q;

endmodule
